// File: rtl/sr_cmd_driver_pkg.sv
// Shared types for the SR flip-flop command driver: op encodings, FSM states, counter width.
package sr_cmd_pkg;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_SET = 2'b01,
      OP_CLR = 2'b10,
      OP_TGL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StWait,
      StResp
   } state_e;

   // Wide enough for the largest legal pulse (15) or timeout (255) count.
   localparam int unsigned CntW = 8;

   // A phase of N cycles ends when the counter, loaded on entry, reaches zero.
   function automatic logic [CntW-1:0] cnt_load(input int unsigned cycles);
      return CntW'(cycles - 1);
   endfunction

endpackage

// File: rtl/sr_cmd_driver_if.sv
// Command-side handshake and status bundle for sr_cmd_driver.
interface sr_cmd_driver_if;
   import sr_cmd_pkg::*;

   logic cmd_valid;
   op_e  cmd_op;
   logic cmd_ready;
   logic busy;
   logic done;
   logic err;

   modport master (
      output cmd_valid,
      output cmd_op,
      input  cmd_ready,
      input  busy,
      input  done,
      input  err
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      output cmd_ready,
      output busy,
      output done,
      output err
   );

endinterface

// File: rtl/sr_cmd_driver_timer.sv
// Loadable down-counter with zero flag; shared by the pulse-width and timeout phases.
module sr_cmd_timer
   import sr_cmd_pkg::*;
(
   input  logic            clk_i,
   input  logic            reset_ni,
   input  logic            load_i,
   input  logic [CntW-1:0] load_val_i,
   input  logic            dec_i,
   output logic            zero_o
);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Saturates at zero instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_cmd_driver.sv
// Drives non-overlapping s/r pulses to an external SR flip-flop and confirms via feedback.
// Define SR_CMD_DRIVER_QBAR_CHECK_EN to also require qbar_fb == ~target for a match.
module sr_cmd_driver
   import sr_cmd_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 8
) (
   input  logic               clk,
   input  logic               reset,
   sr_cmd_driver_if.slave     cmd,
   output logic               s,
   output logic               r,
   input  logic               q_fb,
   input  logic               qbar_fb
);

   localparam logic [CntW-1:0] PulseLoad   = cnt_load(PULSE_CYCLES);
   localparam logic [CntW-1:0] TimeoutLoad = cnt_load(TIMEOUT_CYCLES);

   state_e state_q;
   logic   tgt_q, s_q, r_q, done_q, err_q, busy_q;

   logic            accept, acc_tgt, match;
   logic            tmr_load, tmr_dec, tmr_zero;
   logic [CntW-1:0] tmr_val;

   assign accept = (state_q == StIdle) && cmd.cmd_valid;

   always_comb begin
      acc_tgt = 1'b0;
      case (cmd.cmd_op)
         OP_SET:  acc_tgt = 1'b1;
         OP_CLR:  acc_tgt = 1'b0;
         OP_TGL:  acc_tgt = ~q_fb;
         default: acc_tgt = 1'b0;
      endcase
   end

`ifdef SR_CMD_DRIVER_QBAR_CHECK_EN
   assign match = (q_fb == tgt_q) && (qbar_fb == ~tgt_q);
`else
   logic unused_qbar_fb;
   assign unused_qbar_fb = qbar_fb;
   assign match = (q_fb == tgt_q);
`endif

   // Counter is reloaded whenever the FSM leaves a state, so every phase starts fresh.
   always_comb begin
      tmr_load = 1'b1;
      tmr_val  = '0;
      tmr_dec  = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept && (cmd.cmd_op != OP_NOP)) tmr_val = PulseLoad;
         end
         StDrive: begin
            if (tmr_zero) begin
               tmr_val = TimeoutLoad;
            end else begin
               tmr_load = 1'b0;
               tmr_dec  = 1'b1;
            end
         end
         StWait: begin
            if (!(match || tmr_zero)) begin
               tmr_load = 1'b0;
               tmr_dec  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   sr_cmd_timer u_timer (
      .clk_i      (clk),
      .reset_ni   (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         tgt_q   <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  if (cmd.cmd_op == OP_NOP) begin
                     state_q <= StResp;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StDrive;
                     tgt_q   <= acc_tgt;
                     s_q     <= acc_tgt;
                     r_q     <= ~acc_tgt;
                     busy_q  <= 1'b1;
                  end
               end
            end
            StDrive: begin
               if (tmr_zero) begin
                  state_q <= StWait;
                  s_q     <= 1'b0;
                  r_q     <= 1'b0;
               end
            end
            StWait: begin
               if (match || tmr_zero) begin
                  state_q <= StResp;
                  done_q  <= 1'b1;
                  err_q   <= ~match;
                  busy_q  <= 1'b0;
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cmd.cmd_ready = (state_q == StIdle);
   assign cmd.busy      = busy_q;
   assign cmd.done      = done_q;
   assign cmd.err       = err_q;
   assign s             = s_q;
   assign r             = r_q;

endmodule

// File: doc/sr_cmd_driver.md
# sr_cmd_driver

Command-side driver for an external SR flip-flop: accepts set/clear/toggle/no-op commands on a valid/ready handshake and generates clean, non-overlapping `s`/`r` pulses of programmable width. It confirms each command by watching the flip-flop's `q`/`qbar` feedback, with a bounded timeout. It sits between control logic and any `srflipflop` instance, replacing hand-sequenced `s`/`r` stimulus.

## Interface
- `PULSE_CYCLES`, default 2: cycles `s` or `r` is held high per command; legal range 1..15.
- `TIMEOUT_CYCLES`, default 8: maximum cycles spent waiting for feedback after the pulse; legal range 1..255.
- `clk` input, 1 bit: single clock; all logic on its rising edge.
- `reset` input, 1 bit: synchronous, active-low reset.
- `cmd_valid` input, 1 bit: command present.
- `cmd_op` input, 2 bits: 00 NOP, 01 SET, 10 CLEAR, 11 TOGGLE.
- `cmd_ready` output, 1 bit: block can accept a command.
- `s` output, 1 bit: set drive to the flip-flop.
- `r` output, 1 bit: reset drive to the flip-flop.
- `q_fb` input, 1 bit: flip-flop `q`.
- `qbar_fb` input, 1 bit: flip-flop `qbar`.
- `busy` output, 1 bit: a command is in flight.
- `done` output, 1 bit: one-cycle completion pulse.
- `err` output, 1 bit: qualifies `done`; 1 means the command timed out.

## Operation
- FSM states: IDLE, DRIVE, WAIT, RESP.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, latch the target and go to DRIVE. Target is 1 for SET, 0 for CLEAR, and `~q_fb` sampled at the accept edge for TOGGLE.
  - NOP goes directly to RESP with `err`=0.
- DRIVE
  - `s`=target and `r`=~target for exactly `PULSE_CYCLES` cycles, then WAIT.
- WAIT
  - `s`=`r`=0.
  - Each cycle, compare feedback with the target. A match goes to RESP with `err`=0.
  - After `TIMEOUT_CYCLES` WAIT cycles without a match, go to RESP with `err`=1.
- RESP
  - `done`=1 for one cycle, `err` as decided, `cmd_ready`=0. Then IDLE.
- The drive is always issued, even when `q_fb` already equals the target.
- Invariant: `s` and `r` are never both 1 in any cycle.
- `cmd_valid` and `cmd_op` are ignored outside IDLE.
- `busy` = (state is DRIVE or WAIT).
- A single down-counter sized for max(`PULSE_CYCLES`, `TIMEOUT_CYCLES`) serves both DRIVE and WAIT. It is reloaded on every state entry and never wraps.

## Timing
- Reset values (after the clock edge with `reset`=0):
  - state IDLE
  - `s`=`r`=`done`=`err`=`busy`=0
  - `cmd_ready`=1
  - counter and target cleared
- `cmd_ready` is combinational from state; `s`, `r`, `done`, `err` and `busy` are registered.
- Command accepted at edge N:
  - `s`/`r` high in cycles N+1 .. N+PULSE_CYCLES.
  - WAIT begins at cycle N+PULSE_CYCLES+1.
- Feedback first matching in WAIT cycle k (k = 0..TIMEOUT_CYCLES-1) gives `done` in cycle k+1 of WAIT-relative time.
  - Minimum latency from accept to `done` is PULSE_CYCLES+2.
- Timeout gives `done` with `err`=1 at N+PULSE_CYCLES+TIMEOUT_CYCLES+1.
- NOP gives `done` at N+1.
- Back-to-back commands: the next command is accepted in the cycle after RESP.
- Reset mid-operation:
  - `s`/`r` drop to 0 at that edge.
  - The in-flight command is discarded and no `done` is produced.
- Feedback changing during DRIVE is ignored.

## Configuration
- Macro: `SR_CMD_DRIVER_QBAR_CHECK_EN`.
- Defined: a match requires `q_fb`==target AND `qbar_fb`==~target. `q_fb`==`qbar_fb` is treated as no-match, so it runs to timeout.
- Undefined: a match uses `q_fb` only. `qbar_fb` stays a port but is unused.

## Structure
- Package `sr_cmd_pkg` holds:
  - op encodings: OP_NOP, OP_SET, OP_CLR, OP_TGL
  - the state enum
  - counter-width constant
- One natural sub-module, `sr_cmd_timer`: a loadable down-counter with a zero flag, used for both pulse width and timeout.

## Test plan
All scenarios use PULSE_CYCLES=2, TIMEOUT_CYCLES=8, with an `srflipflop` model looped back to the feedback inputs.
- **Reset:** hold `reset`=0 for 3 cycles, then release. Expect `s`=`r`=`done`=`busy`=0 and `cmd_ready`=1. Flip-flop cleared, `q`=0.
- **SET:** SET accepted at edge N. Expect `s`=1 at N+1 and N+2, `q`=1, then `done`=1 with `err`=0 at N+4. Every cycle, check `s&r`=0.
- **CLEAR then TOGGLE back-to-back:**
  - CLEAR accepted after SET: `r` pulses for 2 cycles, `q`=0, `done` with `err`=0.
  - TOGGLE accepted in the cycle after that RESP: `s` pulses for 2 cycles, `q`=1.
- **Timeout:** disconnect the feedback (`q_fb` stuck 0), then SET. Expect `done`=1 with `err`=1 exactly 11 cycles after accept. `busy` is high for 10 cycles.
- **NOP and ignored inputs:**
  - NOP gives `done` at N+1 with no `s`/`r` activity.
  - `cmd_valid` pulsed during DRIVE is ignored.
- **Reset mid-DRIVE, plus macro check:**
  - Assert reset mid-DRIVE: `s`=0 at the next edge and no `done`.
  - With the macro defined, force `qbar_fb`=`q_fb`=1: expect `err`=1 at timeout. Without the macro, the same stimulus gives `err`=0.
